// File: rtl/exc_irq_ctrl.sv
// exc_irq_ctrl - multi-channel exception / interrupt controller.
//
// Latches N_IRQ external interrupt requests (rising-edge or level),
// applies a software mask, and prioritises them against the synchronous
// NotAnInstr exception. It then runs a request / acknowledge / return
// handshake with the pipeline.
//
// Ports:
//   clk          system clock, all state on rising edge
//   reset        synchronous, active-low reset
//   ExtIRQ       external interrupt request lines
//   NotAnInstr   decoder flag: current instruction invalid
//   ExcAck       pipeline has taken the exception (vector fetch done)
//   ERet         decoded ERET instruction (return from handler)
//   MaskWe       mask register write enable
//   MaskData     new mask value (1 = channel masked)
//   Exc          exception request to the datapath
//   EStatus      cause code (0000 none, 0010 NotAnInstr, 1kkk IRQ k)
//   ExtIAck      one-hot, single-cycle acknowledge to the serviced channel
//   InHandler    high while the handler executes
//   DoubleFault  sticky: NotAnInstr seen while in the handler
//   IrqPending   current pending bits
//   fsm_state    FSM state for debug (0 IDLE, 1 REQ, 2 HANDLER)
//
// Handshake: Exc is a request held until ExcAck. A request is taken on the
// clock edge where Exc and ExcAck are both high. ExcAck with no request
// outstanding, and ERet outside the handler, are ignored.
module exc_irq_ctrl #(
  parameter int               N_IRQ     = 4,
  parameter bit               EDGE_MODE = 1'b1,
  parameter logic [N_IRQ-1:0] MASK_RST  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] ExtIRQ,
  input  logic             NotAnInstr,
  input  logic             ExcAck,
  input  logic             ERet,
  input  logic             MaskWe,
  input  logic [N_IRQ-1:0] MaskData,
  output logic             Exc,
  output logic [3:0]       EStatus,
  output logic [N_IRQ-1:0] ExtIAck,
  output logic             InHandler,
  output logic             DoubleFault,
  output logic [N_IRQ-1:0] IrqPending,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HANDLER = 2'd2
  } state_t;

  localparam logic [3:0] CAUSE_NONE = 4'b0000;
  localparam logic [3:0] CAUSE_NAI  = 4'b0010;

  state_t           state, state_n;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] pend;
  logic [N_IRQ-1:0] req_vec;
  logic [N_IRQ-1:0] ack_vec;
  logic [3:0]       cause_q;
  logic [3:0]       sel_cause;
  logic [2:0]       sel_idx;
  logic [2:0]       ack_idx;
  logic             irq_any;
  logic             exc_c;
  logic [3:0]       estat_c;
  logic             in_handler_c;
  logic             ack_fire;
  logic             latch_cause;
  logic             double_fault_q;

  // Pending bits: latched on rising edges, or a straight copy of the lines.
  generate
    if (EDGE_MODE) begin : g_edge
      logic [N_IRQ-1:0] irq_prev;
      logic [N_IRQ-1:0] pend_q;
      always_ff @(posedge clk) begin
        if (!reset) begin
          irq_prev <= '0;
          pend_q   <= '0;
        end else begin
          irq_prev <= ExtIRQ;
          // A new edge in the same cycle as the ack keeps the bit set.
          pend_q   <= (pend_q & ~ack_vec) | (ExtIRQ & ~irq_prev);
        end
      end
      assign pend = pend_q;
    end else begin : g_level
      assign pend = ExtIRQ;
    end
  endgenerate

  assign req_vec = pend & ~mask;
  assign irq_any = |req_vec;

  // Lowest-index unmasked pending channel wins.
  always_comb begin
    sel_idx = 3'd0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (req_vec[k]) sel_idx = 3'(k);
    end
  end

  always_comb begin
    if (NotAnInstr)   sel_cause = CAUSE_NAI;
    else if (irq_any) sel_cause = {1'b1, sel_idx};
    else              sel_cause = CAUSE_NONE;
  end

  always_comb begin
    state_n      = state;
    exc_c        = 1'b0;
    estat_c      = CAUSE_NONE;
    in_handler_c = 1'b0;
    ack_fire     = 1'b0;
    ack_idx      = sel_idx;
    latch_cause  = 1'b0;
    case (state)
      IDLE: begin
        exc_c   = NotAnInstr | irq_any;
        estat_c = sel_cause;
        if (exc_c) begin
          latch_cause = 1'b1;
          if (ExcAck) begin
            state_n  = HANDLER;
            ack_fire = ~NotAnInstr;
          end else begin
            state_n = REQ;
          end
        end
      end
      REQ: begin
        // Cause stays frozen even if a higher-priority event arrives.
        exc_c   = 1'b1;
        estat_c = cause_q;
        ack_idx = cause_q[2:0];
        if (ExcAck) begin
          state_n  = HANDLER;
          ack_fire = cause_q[3];
        end
      end
      HANDLER: begin
        in_handler_c = 1'b1;
        estat_c      = cause_q;
        if (ERet) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ack_vec = '0;
    for (int k = 0; k < N_IRQ; k++) begin
      ack_vec[k] = reset & ack_fire & (ack_idx == 3'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      mask           <= MASK_RST;
      cause_q        <= CAUSE_NONE;
      double_fault_q <= 1'b0;
    end else begin
      state <= state_n;
      if (MaskWe)      mask    <= MaskData;
      if (latch_cause) cause_q <= sel_cause;
      if (state == HANDLER && NotAnInstr) double_fault_q <= 1'b1;
    end
  end

  assign Exc         = reset & exc_c;
  assign EStatus     = reset ? estat_c : CAUSE_NONE;
  assign ExtIAck     = ack_vec;
  assign InHandler   = reset & in_handler_c;
  assign DoubleFault = double_fault_q;
  assign IrqPending  = pend;
  assign fsm_state   = state;

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// tb_exc_irq_ctrl - directed bench for exc_irq_ctrl (N_IRQ=4, edge mode).
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later,
// well away from the next edge.
module tb_exc_irq_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] ExtIRQ;
  logic       NotAnInstr;
  logic       ExcAck;
  logic       ERet;
  logic       MaskWe;
  logic [3:0] MaskData;
  logic       Exc;
  logic [3:0] EStatus;
  logic [3:0] ExtIAck;
  logic       InHandler;
  logic       DoubleFault;
  logic [3:0] IrqPending;
  logic [1:0] fsm_state;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HND  = 2'd2;

  exc_irq_ctrl #(.N_IRQ(4), .EDGE_MODE(1'b1), .MASK_RST(4'b0000)) dut (
    .clk(clk), .reset(reset), .ExtIRQ(ExtIRQ), .NotAnInstr(NotAnInstr),
    .ExcAck(ExcAck), .ERet(ERet), .MaskWe(MaskWe), .MaskData(MaskData),
    .Exc(Exc), .EStatus(EStatus), .ExtIAck(ExtIAck), .InHandler(InHandler),
    .DoubleFault(DoubleFault), .IrqPending(IrqPending), .fsm_state(fsm_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_eret();
    ERet = 1'b1;
    tick();
    ERet = 1'b0;
  endtask

  initial begin
    reset = 1'b0; ExtIRQ = '0; NotAnInstr = 1'b0; ExcAck = 1'b0;
    ERet = 1'b0; MaskWe = 1'b0; MaskData = '0;
    tick(); tick();

    // Outputs forced low while in reset, even with a live request.
    NotAnInstr = 1'b1; settle();
    check("rst_exc", Exc, 0);
    check("rst_estatus", EStatus, 0);
    check("rst_inhandler", InHandler, 0);
    NotAnInstr = 1'b0;
    reset = 1'b1; tick(); settle();
    check("rst_state", fsm_state, S_IDLE);
    check("rst_pend", IrqPending, 0);
    check("rst_dfault", DoubleFault, 0);

    // NotAnInstr taken immediately.
    NotAnInstr = 1'b1; ExcAck = 1'b1; settle();
    check("nai_exc", Exc, 1);
    check("nai_estatus", EStatus, 4'b0010);
    check("nai_ack", ExtIAck, 0);
    tick(); NotAnInstr = 1'b0; ExcAck = 1'b0; settle();
    check("nai_inhandler", InHandler, 1);
    check("nai_state", fsm_state, S_HND);
    check("nai_hnd_exc", Exc, 0);
    check("nai_hnd_estatus", EStatus, 4'b0010);
    do_eret(); settle();
    check("nai_ret_state", fsm_state, S_IDLE);
    check("nai_ret_estatus", EStatus, 0);
    check("nai_ret_exc", Exc, 0);

    // IRQ2 pulse, ack delayed 3 cycles.
    ExtIRQ = 4'b0100; tick(); ExtIRQ = 4'b0000; settle();
    check("irq2_pend", IrqPending, 4'b0100);
    check("irq2_idle_exc", Exc, 1);
    check("irq2_idle_estatus", EStatus, 4'b1010);
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      check("irq2_req_state", fsm_state, S_REQ);
      check("irq2_req_exc", Exc, 1);
      check("irq2_req_estatus", EStatus, 4'b1010);
      check("irq2_req_noack", ExtIAck, 0);
      tick();
    end
    ExcAck = 1'b1; settle();
    check("irq2_ack", ExtIAck, 4'b0100);
    tick(); ExcAck = 1'b0; settle();
    check("irq2_hnd_state", fsm_state, S_HND);
    check("irq2_ack_once", ExtIAck, 0);
    check("irq2_pend_clr", IrqPending, 0);
    do_eret(); settle();
    check("irq2_ret_exc", Exc, 0);

    // IRQ3 and IRQ1 together with channel 1 masked.
    MaskWe = 1'b1; MaskData = 4'b0010; tick(); MaskWe = 1'b0;
    ExtIRQ = 4'b1010; tick(); ExtIRQ = 4'b0000; settle();
    check("mask_exc", Exc, 1);
    check("mask_estatus", EStatus, 4'b1011);
    ExcAck = 1'b1; settle();
    check("mask_ack3", ExtIAck, 4'b1000);
    tick(); ExcAck = 1'b0; settle();
    check("mask_pend", IrqPending, 4'b0010);
    check("mask_hnd_exc", Exc, 0);
    do_eret(); settle();
    check("mask_hidden", Exc, 0);
    MaskWe = 1'b1; MaskData = 4'b0000; tick(); MaskWe = 1'b0; settle();
    check("unmask_exc", Exc, 1);
    check("unmask_estatus", EStatus, 4'b1001);
    ExcAck = 1'b1; settle();
    check("unmask_ack1", ExtIAck, 4'b0010);
    tick(); ExcAck = 1'b0;
    do_eret(); settle();
    check("unmask_pend_clr", IrqPending, 0);

    // Double fault inside the handler.
    NotAnInstr = 1'b1; ExcAck = 1'b1; tick(); ExcAck = 1'b0; settle();
    check("df_exc", Exc, 0);
    tick(); NotAnInstr = 1'b0; settle();
    check("df_set", DoubleFault, 1);
    check("df_state", fsm_state, S_HND);
    do_eret(); settle();
    check("df_sticky", DoubleFault, 1);
    check("df_ret_state", fsm_state, S_IDLE);

    // New IRQ0 edge in the same cycle as its ack.
    ExtIRQ = 4'b0001; tick(); ExtIRQ = 4'b0000;
    tick(); settle();
    check("re_req_state", fsm_state, S_REQ);
    ExtIRQ = 4'b0001; ExcAck = 1'b1; settle();
    check("re_ack0", ExtIAck, 4'b0001);
    tick(); ExtIRQ = 4'b0000; ExcAck = 1'b0; settle();
    check("re_pend_kept", IrqPending, 4'b0001);
    check("re_hnd_state", fsm_state, S_HND);
    do_eret(); settle();
    check("re_second_exc", Exc, 1);
    check("re_second_estatus", EStatus, 4'b1000);
    ExcAck = 1'b1; tick(); ExcAck = 1'b0; settle();
    check("re_second_clr", IrqPending, 0);
    do_eret();

    // Reset while in REQ with two channels pending.
    ExtIRQ = 4'b0110; tick(); ExtIRQ = 4'b0000; tick(); settle();
    check("rr_state", fsm_state, S_REQ);
    check("rr_pend", IrqPending, 4'b0110);
    check("rr_estatus", EStatus, 4'b1001);
    reset = 1'b0; settle();
    check("rr_forced_exc", Exc, 0);
    check("rr_forced_estatus", EStatus, 0);
    tick(); reset = 1'b1; settle();
    check("rr_idle", fsm_state, S_IDLE);
    check("rr_pend_clr", IrqPending, 0);
    check("rr_exc", Exc, 0);
    check("rr_estatus0", EStatus, 0);
    check("rr_dfault_clr", DoubleFault, 0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
